// File: rtl/dot_product_accumulator.sv
// Accumulates N_TERMS unsigned 8-bit products into one result, with a sticky overflow flag.
// Input and output use valid/ready handshakes. A product is added one cycle after it is accepted.
module dot_product_accumulator #(
  parameter int N_TERMS   = 4,
  parameter int ACC_WIDTH = 16,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [7:0]           prod,
  input  logic                 sync_clr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_sum,
  output logic                 out_ovf
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [CNT_WIDTH-1:0] N_CNT = CNT_WIDTH'(N_TERMS);
  localparam logic [CNT_WIDTH-1:0] ONE   = CNT_WIDTH'(1);

  logic [1:0]           state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_in_q, cnt_in_d;
  logic [CNT_WIDTH-1:0] cnt_add_q, cnt_add_d;
  logic [7:0]           p_q, p_d;
  logic                 v_q, v_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                 ovf_q, ovf_d;
  logic [ACC_WIDTH-1:0] out_sum_d;
  logic                 out_ovf_d, out_valid_d, in_ready_d;
  logic                 accept;
  logic [ACC_WIDTH:0]   sum_ext;

  always_comb begin
    // NOTE: every signal gets a default first, so no path through this block can infer a latch.
    accept      = in_valid && in_ready;
    state_d     = state_q;
    cnt_in_d    = cnt_in_q;
    cnt_add_d   = cnt_add_q;
    p_d         = p_q;
    v_d         = 1'b0;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid;
    out_sum_d   = out_sum;
    out_ovf_d   = out_ovf;
    // The first term of a result starts from zero, so stale acc contents never leak in.
    sum_ext     = ((cnt_add_q == '0) ? '0 : {1'b0, acc_q}) + (ACC_WIDTH + 1)'(p_q);

    if (accept) begin
      p_d      = prod;
      v_d      = 1'b1;
      cnt_in_d = cnt_in_q + ONE;
      if (state_q == IDLE) state_d = ACCUM;
    end

    if (v_q) begin
      acc_d     = sum_ext[ACC_WIDTH-1:0];
      ovf_d     = ovf_q | sum_ext[ACC_WIDTH];
      cnt_add_d = cnt_add_q + ONE;
      if (cnt_add_d == N_CNT) begin
        state_d     = DONE;
        out_sum_d   = acc_d;
        out_ovf_d   = ovf_d;
        out_valid_d = 1'b1;
      end
    end

    if (state_q == DONE && out_valid && out_ready) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
      acc_d       = '0;
      ovf_d       = 1'b0;
      cnt_in_d    = '0;
      cnt_add_d   = '0;
    end

    // An abort wins over the accept, accumulate and output handshake that fall on the same edge.
    if (sync_clr) begin
      state_d     = IDLE;
      v_d         = 1'b0;
      acc_d       = '0;
      ovf_d       = 1'b0;
      cnt_in_d    = '0;
      cnt_add_d   = '0;
      out_valid_d = 1'b0;
      out_sum_d   = '0;
      out_ovf_d   = 1'b0;
    end

    in_ready_d = (state_d != DONE) && (cnt_in_d < N_CNT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_in_q  <= '0;
      cnt_add_q <= '0;
      p_q       <= '0;
      v_q       <= 1'b0;
      acc_q     <= '0;
      ovf_q     <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_ovf   <= 1'b0;
      in_ready  <= 1'b0;
    end else begin
      // NOTE: clocked state uses non-blocking assignments, so every register samples pre-edge values.
      state_q   <= state_d;
      cnt_in_q  <= cnt_in_d;
      cnt_add_q <= cnt_add_d;
      p_q       <= p_d;
      v_q       <= v_d;
      acc_q     <= acc_d;
      ovf_q     <= ovf_d;
      out_valid <= out_valid_d;
      out_sum   <= out_sum_d;
      out_ovf   <= out_ovf_d;
      in_ready  <= in_ready_d;
    end
  end

endmodule
